// File: rtl/load_store_unit.sv
// load_store_unit: hart-side load/store initiator for the memory request bus.
// Splits word-crossing loads into two aligned reads and faults bad accesses.
package lsu_pkg;
    localparam int XLEN = 32;

    localparam logic [1:0] W_BYTE = 2'b00;
    localparam logic [1:0] W_HALF = 2'b01;
    localparam logic [1:0] W_WORD = 2'b10;

    typedef struct packed {
        logic [XLEN-1:0] addr;
        logic            wenable;
        logic [1:0]      wwidth;
        logic [XLEN-1:0] wdata;
    } mem_control_t;
endpackage

module load_store_unit
    import lsu_pkg::*;
#(
    parameter int              READ_LATENCY        = 1,
    parameter logic [XLEN-1:0] OUTPUT_PERIPH_START = 32'h1800
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_store,
    input  logic [1:0]      req_width,
    input  logic            req_unsigned,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output mem_control_t    mem_ctrl,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            resp_valid,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_fault
);

    localparam int CW = $clog2(READ_LATENCY + 1);
    localparam logic [CW-1:0] LAST = CW'(READ_LATENCY);

    typedef enum logic [2:0] {
        IDLE,
        ACCESS0,
        ACCESS1,
        RESP,
        FAULT
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic            r_store;
    logic            r_split;
    logic            r_unsigned;
    logic [1:0]      r_width;
    logic [1:0]      r_off;
    logic [XLEN-1:0] lo;

    logic [1:0]      size_m1;
    logic [XLEN:0]   last_byte;
    logic            load_fault;
    logic            store_misal;
    logic            fault;
    logic            split;
    logic [XLEN-1:0] aligned;

    assign req_ready = (state == IDLE) && !reset;

    function automatic logic [XLEN-1:0] extract(
        input logic [XLEN-1:0] l,
        input logic [XLEN-1:0] h,
        input logic [1:0]      off,
        input logic [1:0]      w,
        input logic            uns
    );
        logic [2*XLEN-1:0] v;
        logic              s;
        logic [XLEN-1:0]   r;
        v = {h, l} >> {off, 3'b000};
        r = v[XLEN-1:0];
        if (w == W_BYTE) begin
            s = !uns && v[7];
            r = {{(XLEN-8){s}}, v[7:0]};
        end else if (w == W_HALF) begin
            s = !uns && v[15];
            r = {{(XLEN-16){s}}, v[15:0]};
        end
        return r;
    endfunction

    // Classify the incoming request: fault, split, aligned read address.
    always_comb begin
        size_m1 = 2'd3;
        if (req_width == W_BYTE) size_m1 = 2'd0;
        else if (req_width == W_HALF) size_m1 = 2'd1;
        last_byte   = {1'b0, req_addr} + {{(XLEN-1){1'b0}}, size_m1};
        load_fault  = last_byte >= {1'b0, OUTPUT_PERIPH_START};
        store_misal = (size_m1 == 2'd1 && req_addr[0])
                   || (size_m1 == 2'd3 && req_addr[1:0] != 2'b00);
        fault       = req_store ? store_misal : load_fault;
        split       = !req_store
                   && ((size_m1 == 2'd1 && req_addr[1:0] == 2'b11)
                    || (size_m1 == 2'd3 && req_addr[1:0] != 2'b00));
        aligned     = {req_addr[XLEN-1:2], 2'b00};
    end

    // Access sequencer: drives the memory bus and produces the response pulse.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state            <= IDLE;
            cnt              <= '0;
            r_store          <= 1'b0;
            r_split          <= 1'b0;
            r_unsigned       <= 1'b0;
            r_width          <= W_WORD;
            r_off            <= 2'b00;
            lo               <= '0;
            mem_ctrl.addr    <= '0;
            mem_ctrl.wenable <= 1'b0;
            mem_ctrl.wwidth  <= W_WORD;
            mem_ctrl.wdata   <= '0;
            resp_valid       <= 1'b0;
            resp_rdata       <= '0;
            resp_fault       <= 1'b0;
        end else begin
            mem_ctrl.wenable <= 1'b0;
            resp_valid       <= 1'b0;
            resp_fault       <= 1'b0;
            resp_rdata       <= '0;
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        r_store    <= req_store;
                        r_split    <= split;
                        r_unsigned <= req_unsigned;
                        r_width    <= req_width;
                        r_off      <= req_addr[1:0];
                        cnt        <= '0;
                        if (fault) begin
                            state      <= FAULT;
                            resp_valid <= 1'b1;
                            resp_fault <= 1'b1;
                        end else if (req_store) begin
                            state            <= ACCESS0;
                            mem_ctrl.addr    <= req_addr;
                            mem_ctrl.wenable <= 1'b1;
                            mem_ctrl.wwidth  <= req_width;
                            mem_ctrl.wdata   <= req_wdata;
                        end else begin
                            state         <= ACCESS0;
                            mem_ctrl.addr <= aligned;
                        end
                    end
                end
                ACCESS0: begin
                    if (r_store) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                    end else if (cnt == LAST) begin
                        cnt <= '0;
                        if (r_split) begin
                            lo            <= mem_rdata;
                            state         <= ACCESS1;
                            mem_ctrl.addr <= mem_ctrl.addr + XLEN'(4);
                        end else begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_rdata <= extract(mem_rdata, '0, r_off,
                                                  r_width, r_unsigned);
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ACCESS1: begin
                    if (cnt == LAST) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_rdata <= extract(lo, mem_rdata, r_off,
                                              r_width, r_unsigned);
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP:    state <= IDLE;
                FAULT:   state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Hart-side initiator for the memory block's request interface.
- Accepts one load or store from the execute stage and drives the memory control bundle (addr, wenable, wwidth, wdata).
- Loads: waits out the synchronous read latency, then extracts and extends the addressed byte, halfword or word.
- ROM and RAM reads are word-oriented, so every load issues word-aligned addresses. Word-crossing loads are split into two aligned reads; misaligned stores and unreadable regions are faulted.

Parameters:
READ_LATENCY, 1, cycles from the address being driven on mem_ctrl to valid mem_rdata (must be >= 1)
OUTPUT_PERIPH_START, 32'h1800, first address of the write-only output peripheral region (loads there fault)

Ports:
clock  input  1  system clock
reset  input  1  asynchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  unit idle; a request is accepted when req_valid & req_ready at posedge
req_store  input  1  1 = store, 0 = load
req_width  input  2  byte/halfword/word, same encoding as mem_control_t wwidth
req_unsigned  input  1  loads only: zero-extend instead of sign-extend
req_addr  input  XLEN  byte address
req_wdata  input  XLEN  store data, LSB-aligned
mem_ctrl  output  mem_control_t  addr/wenable/wwidth/wdata to memory
mem_rdata  input  XLEN  read data from memory
resp_valid  output  1  one-cycle completion pulse; no backpressure
resp_rdata  output  XLEN  extended load result; 0 for stores and faults
resp_fault  output  1  valid with resp_valid; access rejected

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values: req_ready=0 while reset is high, 1 in the first cycle after release. resp_valid=0, resp_rdata=0, resp_fault=0. mem_ctrl.addr=0, wenable=0, wwidth=word, wdata=0. State=IDLE.
- States: IDLE, ACCESS0, ACCESS1, RESP, FAULT.
- req_ready=1 only in IDLE. Request fields are registered at acceptance (edge ending cycle T).
- Fault checks at acceptance. Any fault goes to FAULT with no memory access and wenable never asserted:
  - Store misaligned: halfword with addr[0]=1, or word with addr[1:0]!=0.
  - Load whose last byte (addr+size-1) is >= OUTPUT_PERIPH_START.
- FAULT (T+1): resp_valid=1, resp_fault=1, resp_rdata=0, then IDLE.
- Store, ACCESS0 (T+1):
  - mem_ctrl.addr=req_addr unmodified; wwidth=req_width; wdata=req_wdata; wenable=1 for exactly this one cycle.
  - Then RESP (T+2): resp_valid=1, fault 0, rdata 0.
- Load, ACCESS0:
  - mem_ctrl.addr = req_addr & ~3; wenable=0.
  - Address held for READ_LATENCY+1 cycles; mem_rdata captured into lo at the edge ending cycle T+1+READ_LATENCY.
- Load split condition: halfword with addr[1:0]=3, or word with addr[1:0]!=0.
  - Split: ACCESS1 drives aligned+4 starting T+2+READ_LATENCY and captures hi the same way; resp at T+3+2*READ_LATENCY.
  - Unsplit: resp at T+2+READ_LATENCY.
- A per-access counter 0..READ_LATENCY times each ACCESS state.
- Extraction:
  - v = {hi, lo} >> (8*addr[1:0]), where hi=0 if unsplit.
  - byte: v[7:0]; half: v[15:0]; word: v[31:0].
  - Sign-extend from the top bit unless req_unsigned; word ignores req_unsigned.
- resp_valid is high for exactly one cycle per accepted request, then IDLE. req_ready rises in the cycle after resp_valid.
- Outside store ACCESS0, wenable=0. addr, wwidth and wdata hold their last value.
- Back-to-back requests: the next request can be accepted the cycle after resp_valid. req_valid while busy is ignored (not queued).
- Reset mid-operation: immediate (asynchronous) wenable=0 and resp_valid=0. The in-flight request is dropped with no response; IDLE after release.

Test Plan:
1. Store word 0xDEADBEEF to 0x0804, accepted at T -> T+1 only: wenable=1, addr=0x0804, wwidth=word, wdata=0xDEADBEEF; T+2: resp_valid=1, fault=0.
2. Signed byte load 0x0805 (mem 0x0804=0xDEADBEEF, L=1) -> mem_ctrl.addr=0x0804; resp at T+3, rdata=0xFFFFFFBE; unsigned repeat -> 0x000000BE; half signed at 0x0806 -> 0xFFFFDEAD.
3. Word load 0x0806 (0x0804=0xDEADBEEF, 0x0808=0x11223344) -> addrs 0x0804 then 0x0808; resp at T+5, rdata=0x3344DEAD; req_ready=0 throughout, second req_valid ignored.
4. Halfword store to 0x0801 -> resp at T+1 with fault=1, rdata=0; wenable never 1; word load at 0x17FE and byte load at 0x1800 -> fault, mem_ctrl.addr unchanged.
5. READ_LATENCY=2, word load 0x0808 -> addr held 3 cycles; resp at T+4 with 0x11223344.
6. Reset pulsed during ACCESS1 of test 3 -> resp_valid never asserts, wenable=0; after release req_ready=1 next cycle; byte load 0x0804 completes with 0xFFFFFFEF.
